seg7_scan_reader: RTL and testbench

- Monitors the multiplexed 7-segment display bus (digit-select lines plus shared segment bus) driven by the clock's display path.
- Converts each settled segment pattern back into a 4-bit digit code and assembles one complete display frame.
- Used for on-chip self-test and debug readback of what the clock is showing.

---
 rtl/seg7_scan_reader.sv | 212 +++++++++++++++++++++
 tb/tb_seg7_scan_reader.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: decodes a multiplexed 7-segment scan back into a frame of digit codes.
// Optional frame compare against i_expected is enabled by defining SEG7_SCAN_COMPARE_EN.
module seg7_scan_reader #(
   parameter int NUM_DIGITS       = 6,
   parameter int SETTLE_CYCLES    = 4,
   parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [NUM_DIGITS-1:0]   i_anode,
   input  logic [7:0]              i_seg,
   input  logic                    i_clear,
   output logic [4*NUM_DIGITS-1:0] o_digits,
   output logic [NUM_DIGITS-1:0]   o_dp,
   output logic                    o_frame_valid,
   output logic                    o_bad_code,
`ifdef SEG7_SCAN_COMPARE_EN
   output logic                    o_anode_err,
   input  logic [4*NUM_DIGITS-1:0] i_expected,
   output logic                    o_mismatch
`else
   output logic                    o_anode_err
`endif
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W = $clog2(NUM_DIGITS + 1);
   localparam logic [7:0] SETTLE_TGT = 8'(SETTLE_CYCLES);
   localparam logic [NUM_DIGITS-1:0] ANODE_IDLE = {NUM_DIGITS{ANODE_ACTIVE_LOW}};

   typedef enum logic [1:0] {
      ST_WAIT,
      ST_SETTLE,
      ST_HOLD
   } state_t;

   logic [NUM_DIGITS-1:0]       r_anode;
   logic [7:0]                  r_seg;
   state_t                      r_state;
   state_t                      w_state_nxt;
   logic [7:0]                  r_cnt;
   logic [7:0]                  w_cnt_nxt;
   logic [IDX_W-1:0]            r_prev_idx;
   logic [7:0]                  r_prev_seg;
   logic [NUM_DIGITS-1:0][3:0]  r_shadow;
   logic [NUM_DIGITS-1:0]       r_shadow_dp;
   logic [NUM_DIGITS-1:0]       r_seen;
   logic [NUM_DIGITS-1:0]       w_seen_nxt;
   logic [4*NUM_DIGITS-1:0]     w_shadow_flat;
   logic [NUM_DIGITS-1:0]       w_sel;
   logic [CNT_W-1:0]            w_nact;
   logic [IDX_W-1:0]            w_idx;
   logic                        w_valid;
   logic                        w_multi;
   logic                        w_same;
   logic [3:0]                  w_code;
   logic                        w_unknown;
   logic                        w_capture;
   logic                        w_complete;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_anode <= ANODE_IDLE;
         r_seg   <= '1;
      end else begin
         r_anode <= i_anode;
         r_seg   <= i_seg;
      end
   end

   // Normalise polarity so a 1 always means "selected".
   assign w_sel = r_anode ^ ANODE_IDLE;

   always_comb begin
      w_nact = '0;
      w_idx  = '0;
      for (int unsigned k = NUM_DIGITS; k > 0; k--) begin
         if (w_sel[k-1]) begin
            w_nact = w_nact + CNT_W'(1);
            w_idx  = IDX_W'(k - 1);
         end
      end
   end

   assign w_valid = (w_nact == CNT_W'(1));
   assign w_multi = (w_nact > CNT_W'(1));
   assign w_same  = (w_idx == r_prev_idx) && (r_seg == r_prev_seg);

   always_comb begin
      w_code    = 4'hF;
      w_unknown = 1'b0;
      case (r_seg[6:0])
         7'h40:   w_code = 4'd0;
         7'h79:   w_code = 4'd1;
         7'h24:   w_code = 4'd2;
         7'h30:   w_code = 4'd3;
         7'h19:   w_code = 4'd4;
         7'h12:   w_code = 4'd5;
         7'h02:   w_code = 4'd6;
         7'h78:   w_code = 4'd7;
         7'h00:   w_code = 4'd8;
         7'h10:   w_code = 4'd9;
         7'h46:   w_code = 4'd12;
         7'h09:   w_code = 4'd13;
         7'h4E:   w_code = 4'd14;
         7'h7F:   w_code = 4'd15;
         default: begin
            w_code    = 4'd15;
            w_unknown = 1'b1;
         end
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_capture   = 1'b0;
      if (!w_valid) begin
         w_state_nxt = ST_WAIT;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            ST_SETTLE: w_cnt_nxt = !w_same ? 8'd1 : ((r_cnt == '1) ? r_cnt : r_cnt + 8'd1);
            ST_HOLD:   w_cnt_nxt = w_same ? r_cnt : 8'd1;
            default:   w_cnt_nxt = 8'd1;
         endcase
         // One capture per dwell: an unchanged sample in HOLD never re-arms the counter.
         if (r_state == ST_HOLD && w_same) begin
            w_state_nxt = ST_HOLD;
         end else if (w_cnt_nxt >= SETTLE_TGT) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_HOLD;
         end else begin
            w_state_nxt = ST_SETTLE;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= ST_WAIT;
         r_cnt      <= '0;
         r_prev_idx <= '0;
         r_prev_seg <= '1;
      end else begin
         r_prev_idx <= w_idx;
         r_prev_seg <= r_seg;
         if (i_clear) begin
            r_state <= ST_WAIT;
            r_cnt   <= '0;
         end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
         end
      end
   end

   assign w_complete    = &r_seen;
   assign w_shadow_flat = r_shadow;

   // Completion clears seen; a capture landing in the same cycle starts the next frame.
   always_comb begin
      w_seen_nxt = w_complete ? '0 : r_seen;
      if (w_capture) w_seen_nxt[w_idx] = 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_shadow      <= '1;
         r_shadow_dp   <= '0;
         r_seen        <= '0;
         o_digits      <= '1;
         o_dp          <= '0;
         o_frame_valid <= 1'b0;
         o_bad_code    <= 1'b0;
         o_anode_err   <= 1'b0;
      end else if (i_clear) begin
         r_shadow      <= '1;
         r_shadow_dp   <= '0;
         r_seen        <= '0;
         o_frame_valid <= 1'b0;
         o_bad_code    <= 1'b0;
         o_anode_err   <= 1'b0;
      end else begin
         o_frame_valid <= w_complete;
         r_seen        <= w_seen_nxt;
         if (w_complete) begin
            o_digits <= w_shadow_flat;
            o_dp     <= r_shadow_dp;
         end
         if (w_capture) begin
            r_shadow[w_idx]    <= w_code;
            r_shadow_dp[w_idx] <= ~r_seg[7];
            if (w_unknown) o_bad_code <= 1'b1;
         end
         if (w_multi) o_anode_err <= 1'b1;
      end
   end

`ifdef SEG7_SCAN_COMPARE_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_mismatch <= 1'b0;
      end else if (i_clear) begin
         o_mismatch <= 1'b0;
      end else if (w_complete) begin
         o_mismatch <= (w_shadow_flat != i_expected);
      end
   end
`endif

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Scoreboard bench for seg7_scan_reader: two instances (settle 4 / active-low, settle 1 / active-high)
// driven by one dwell-level stimulus and checked against a frame-level reference model.
module tb_seg7_scan_reader;
   localparam int ND = 6;

   typedef struct packed {
      logic [4*ND-1:0] dig;
      logic [ND-1:0]   dp;
      logic            mis;
   } frame_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            clr;
   logic [ND-1:0]   anode;
   logic [ND-1:0]   anode_hi;
   logic [7:0]      seg;
   logic [4*ND-1:0] expv;
   logic [4*ND-1:0] dig0, dig1;
   logic [ND-1:0]   dp0, dp1;
   logic            fv0, fv1, bad0, bad1, aerr0, aerr1;
`ifdef SEG7_SCAN_COMPARE_EN
   logic            mis0, mis1;
`endif

   int checks   = 0;
   int failures = 0;

   logic [6:0]      pat_tbl [16];
   bit              pat_ok  [16];
   int              m_thr   [2];
   logic [3:0]      m_sh    [2][ND];
   logic            m_dpv   [2][ND];
   logic [ND-1:0]   m_seen  [2];
   logic            m_bad   [2];
   logic            m_aerr  [2];
   logic            m_mis   [2];
   logic [4*ND-1:0] m_odig  [2];
   logic [ND-1:0]   m_odp   [2];
   frame_t          q0[$], q1[$];
   frame_t          f0, f1;
   logic [ND-1:0]   last_act;
   logic [7:0]      last_seg;

   assign anode_hi = ~anode;
   always #5 clk = ~clk;

   seg7_scan_reader #(.NUM_DIGITS(ND), .SETTLE_CYCLES(4), .ANODE_ACTIVE_LOW(1'b1)) u_dut0 (
      .i_clk(clk), .i_rst(rst), .i_anode(anode), .i_seg(seg), .i_clear(clr),
      .o_digits(dig0), .o_dp(dp0), .o_frame_valid(fv0), .o_bad_code(bad0),
`ifdef SEG7_SCAN_COMPARE_EN
      .o_anode_err(aerr0), .i_expected(expv), .o_mismatch(mis0)
`else
      .o_anode_err(aerr0)
`endif
   );

   seg7_scan_reader #(.NUM_DIGITS(ND), .SETTLE_CYCLES(1), .ANODE_ACTIVE_LOW(1'b0)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_anode(anode_hi), .i_seg(seg), .i_clear(clr),
      .o_digits(dig1), .o_dp(dp1), .o_frame_valid(fv1), .o_bad_code(bad1),
`ifdef SEG7_SCAN_COMPARE_EN
      .o_anode_err(aerr1), .i_expected(expv), .o_mismatch(mis1)
`else
      .o_anode_err(aerr1)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic model_clear(input int m, input bit full);
      for (int k = 0; k < ND; k++) begin
         m_sh[m][k]  = 4'hF;
         m_dpv[m][k] = 1'b0;
      end
      m_seen[m] = '0;
      m_bad[m]  = 1'b0;
      m_aerr[m] = 1'b0;
      m_mis[m]  = 1'b0;
      if (full) begin
         m_odig[m] = '1;
         m_odp[m]  = '0;
      end
   endtask

   task automatic model_capture(input int m, input int pos, input logic [7:0] s);
      logic [3:0] code;
      logic       bad;
      frame_t     f;
      code = 4'hF;
      bad  = 1'b1;
      for (int c = 0; c < 16; c++)
         if (pat_ok[c] && pat_tbl[c] == s[6:0]) begin
            code = 4'(c);
            bad  = 1'b0;
         end
      if (bad) m_bad[m] = 1'b1;
      m_sh[m][pos]   = code;
      m_dpv[m][pos]  = ~s[7];
      m_seen[m][pos] = 1'b1;
      if (m_seen[m] == '1) begin
         for (int k = 0; k < ND; k++) begin
            f.dig[4*k +: 4] = m_sh[m][k];
            f.dp[k]         = m_dpv[m][k];
         end
         f.mis = (f.dig != expv);
         if (m == 0) q0.push_back(f);
         else        q1.push_back(f);
         m_odig[m] = f.dig;
         m_odp[m]  = f.dp;
         m_mis[m]  = f.mis;
         m_seen[m] = '0;
      end
   endtask

   task automatic idle(input int n);
      anode    = '1;
      last_act = '0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One dwell: `act` is the active-high set of selected positions, held for `len` cycles.
   task automatic drive(input logic [ND-1:0] act, input logic [7:0] s, input int len);
      int pos;
      int n;
      if (act == last_act && s == last_seg) idle(1);
      anode    = ~act;
      seg      = s;
      last_act = act;
      last_seg = s;
      n = $countones(act);
      if (n == 1) begin
         pos = 0;
         for (int k = 0; k < ND; k++) if (act[k]) pos = k;
         for (int m = 0; m < 2; m++) if (len >= m_thr[m]) model_capture(m, pos, s);
      end else if (n > 1) begin
         m_aerr[0] = 1'b1;
         m_aerr[1] = 1'b1;
      end
      repeat (len) @(posedge clk);
      #1;
   endtask

   task automatic scan(input logic [4*ND-1:0] codes, input int len);
      for (int k = 0; k < ND; k++)
         drive(ND'(1) << k, {1'b1, pat_tbl[codes[4*k +: 4]]}, len);
   endtask

   task automatic pulse_clear();
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      model_clear(0, 1'b0);
      model_clear(1, 1'b0);
   endtask

   task automatic checkpoint(input string tag);
      idle(4);
      @(negedge clk);
      chk({tag, "/dig0"},  32'(dig0),  32'(m_odig[0]));
      chk({tag, "/dp0"},   32'(dp0),   32'(m_odp[0]));
      chk({tag, "/bad0"},  32'(bad0),  32'(m_bad[0]));
      chk({tag, "/aerr0"}, 32'(aerr0), 32'(m_aerr[0]));
      chk({tag, "/fv0"},   32'(fv0),   32'd0);
      chk({tag, "/dig1"},  32'(dig1),  32'(m_odig[1]));
      chk({tag, "/dp1"},   32'(dp1),   32'(m_odp[1]));
      chk({tag, "/bad1"},  32'(bad1),  32'(m_bad[1]));
      chk({tag, "/aerr1"}, 32'(aerr1), 32'(m_aerr[1]));
`ifdef SEG7_SCAN_COMPARE_EN
      chk({tag, "/mis0"},  32'(mis0),  32'(m_mis[0]));
      chk({tag, "/mis1"},  32'(mis1),  32'(m_mis[1]));
`endif
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst && fv0) begin
         if (q0.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL frame0_unexpected actual=pulse expected=no_pulse digits=0x%0h", dig0);
         end else begin
            f0 = q0.pop_front();
            chk("frame0_digits", 32'(dig0), 32'(f0.dig));
            chk("frame0_dp", 32'(dp0), 32'(f0.dp));
`ifdef SEG7_SCAN_COMPARE_EN
            chk("frame0_mismatch", 32'(mis0), 32'(f0.mis));
`endif
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && fv1) begin
         if (q1.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL frame1_unexpected actual=pulse expected=no_pulse digits=0x%0h", dig1);
         end else begin
            f1 = q1.pop_front();
            chk("frame1_digits", 32'(dig1), 32'(f1.dig));
            chk("frame1_dp", 32'(dp1), 32'(f1.dp));
`ifdef SEG7_SCAN_COMPARE_EN
            chk("frame1_mismatch", 32'(mis1), 32'(f1.mis));
`endif
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [ND-1:0] act;
      logic [7:0]    s;
      int            a, b, r;
      int            codes[14] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 12, 13, 14, 15};

      pat_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h7F, 7'h7F, 7'h46, 7'h09, 7'h4E, 7'h7F};
      for (int c = 0; c < 16; c++) pat_ok[c] = (c != 10 && c != 11);
      m_thr[0] = 4;
      m_thr[1] = 1;
      model_clear(0, 1'b1);
      model_clear(1, 1'b1);
      rst      = 1'b1;
      clr      = 1'b0;
      anode    = '1;
      seg      = '1;
      expv     = 24'h123456;
      last_act = '0;
      last_seg = '1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checkpoint("reset");

      // clean scan
      scan(24'h954321, 8);
      checkpoint("clean");
      chk("clean_digits", 32'(dig0), 32'h954321);
      chk("clean_bad", 32'(bad0), 32'd0);

      // short glitch on position 2 then a proper dwell
      drive(6'b000100, 8'hA4, 3);
      drive(6'b000100, 8'hB0, 8);
      drive(6'b000001, 8'h80, 8);
      drive(6'b000010, 8'h80, 8);
      drive(6'b001000, 8'h80, 8);
      drive(6'b010000, 8'h80, 8);
      drive(6'b100000, 8'h80, 8);
      checkpoint("glitch");
      chk("glitch_slot2", 32'(dig0[11:8]), 32'd3);

      // letters and blank, dp lit on position 1
      drive(6'b000001, 8'hC6, 8);
      drive(6'b000010, 8'h09, 8);
      drive(6'b000100, 8'hCE, 8);
      drive(6'b001000, 8'hFF, 8);
      drive(6'b010000, 8'hC0, 8);
      drive(6'b100000, 8'hC0, 8);
      checkpoint("letters");
      chk("letters_digits", 32'(dig0), 32'h00FEDC);
      chk("letters_dp", 32'(dp0), 32'h02);
      chk("letters_bad", 32'(bad0), 32'd0);

      // error flags, then clear
      drive(6'b000001, 8'hD5, 8);
      drive(6'b000110, 8'hC0, 6);
      checkpoint("errors");
      chk("err_bad_sticky", 32'(bad0), 32'd1);
      chk("err_anode_sticky", 32'(aerr0), 32'd1);
      pulse_clear();
      checkpoint("cleared");
      chk("clear_bad", 32'(bad0), 32'd0);
      chk("clear_keeps_digits", 32'(dig0), 32'h00FEDC);
      for (int k = 0; k < ND - 1; k++) drive(ND'(1) << k, 8'hF9, 8);
      checkpoint("after_clear_partial");
      drive(6'b100000, 8'hF9, 8);
      checkpoint("after_clear_full");
      chk("after_clear_digits", 32'(dig0), 32'h111111);

      // reset while instance 0 is settling
      drive(6'b001000, 8'h99, 3);
      rst      = 1'b1;
      anode    = '1;
      last_act = '0;
      model_clear(0, 1'b1);
      model_clear(1, 1'b1);
      @(negedge clk);
      chk("rst_dig0", 32'(dig0), 32'hFFFFFF);
      chk("rst_dp0", 32'(dp0), 32'd0);
      chk("rst_fv0", 32'(fv0), 32'd0);
      chk("rst_dig1", 32'(dig1), 32'hFFFFFF);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < ND - 1; k++) drive(ND'(1) << k, 8'h92, 8);
      checkpoint("after_rst_partial");
      drive(6'b100000, 8'h92, 8);
      checkpoint("after_rst_full");

`ifdef SEG7_SCAN_COMPARE_EN
      scan(24'h754321, 8);
      checkpoint("cmp_diff");
      chk("cmp_mismatch_set", 32'(mis0), 32'd1);
      scan(24'h123456, 8);
      checkpoint("cmp_match");
      chk("cmp_mismatch_clr", 32'(mis0), 32'd0);
`endif

      // randomized dwells
      for (int i = 0; i < 240; i++) begin
         r = $urandom_range(0, 19);
         if (r == 0) begin
            a = $urandom_range(0, ND - 1);
            b = (a + $urandom_range(1, ND - 1)) % ND;
            act = (ND'(1) << a) | (ND'(1) << b);
            drive(act, 8'($urandom), $urandom_range(1, 6));
         end else begin
            act = ND'(1) << $urandom_range(0, ND - 1);
            if (r == 1) s = {1'($urandom_range(0, 1)), 7'($urandom)};
            else        s = {1'($urandom_range(0, 1)), pat_tbl[codes[$urandom_range(0, 13)]]};
            drive(act, s, $urandom_range(1, 7));
         end
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         if (i % 60 == 59) checkpoint("random");
      end

      checkpoint("end");
      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("q1_drained", 32'(q1.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
